// File: rtl/sram_frame_scheduler_if.sv
// Bundles the display-read, writer, swap-control and SRAM bus signals of
// sram_frame_scheduler.
//   slave  : scheduler view (drives slot/pixel_tick, read data, wr_ready,
//            swap status, and the SRAM address/data/strobes).
//   master : client/environment view (display, writer, swap control and
//            SRAM read data).
interface sram_frame_scheduler_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        slot;
  logic              pixel_tick;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              paint_done;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              swap_req;
  logic              swap_pending;
  logic              swap_done;
  logic              front_sel;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dout;
  logic              sram_den;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [DATA_W-1:0] sram_din;

  modport slave (
    output slot, pixel_tick, disp_data, disp_valid, wr_ready,
           swap_pending, swap_done, front_sel,
           sram_addr, sram_dout, sram_den, sram_oe_n, sram_we_n,
    input  disp_req, disp_addr, paint_done, wr_valid, wr_addr, wr_data,
           swap_req, sram_din
  );

  modport master (
    input  slot, pixel_tick, disp_data, disp_valid, wr_ready,
           swap_pending, swap_done, front_sel,
           sram_addr, sram_dout, sram_den, sram_oe_n, sram_we_n,
    output disp_req, disp_addr, paint_done, wr_valid, wr_addr, wr_data,
           swap_req, sram_din
  );
endinterface

// File: rtl/sram_frame_scheduler.sv
// Time-division SRAM scheduler for a double-buffered frame store.
// Each 25 MHz pixel is four clk slots:
//   slot 0 : display read from the front buffer (if requested)
//   slot 1 : write SETUP   (address/data driven, we_n high)
//   slot 2 : write STROBE  (we_n low)
//   slot 3 : write HOLD    (we_n high); buffer swap may occur at its end
// Ports: clk, rst (async, active-low) and the slave modport of
// sram_frame_scheduler_if carrying display, writer, swap and SRAM signals.
// All outputs are registered except wr_ready and pixel_tick (slot decodes).
module sram_frame_scheduler #(
  parameter int unsigned       ADDR_W    = 20,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BUF0_BASE = '0,
  parameter logic [ADDR_W-1:0] BUF1_BASE = 20'h4B000
) (
  input logic                  clk,
  input logic                  rst,
  sram_frame_scheduler_if.slave bus
);

  localparam logic [1:0] SLOT_READ   = 2'd0;
  localparam logic [1:0] SLOT_SETUP  = 2'd1;
  localparam logic [1:0] SLOT_STROBE = 2'd2;
  localparam logic [1:0] SLOT_HOLD   = 2'd3;

  logic [1:0]        slotQ;
  logic              frontSel;
  logic              swapPending;
  logic              swapDone;
  logic              dispValid;
  logic [DATA_W-1:0] dispData;
  logic              wbusy;
  logic [ADDR_W-1:0] sramAddr;
  logic [DATA_W-1:0] sramDout;
  logic              sramDen;
  logic              sramOeN;
  logic              sramWeN;

  logic              swapNow;
  logic              nextFront;
  logic [ADDR_W-1:0] readBase;
  logic [ADDR_W-1:0] writeBase;
  logic [ADDR_W-1:0] readAddr;
  logic [ADDR_W-1:0] writeAddr;

  // The read for slot 0 is registered on the same edge that may swap, so
  // it is addressed from the post-swap front buffer.
  always_comb begin
    swapNow   = (slotQ == SLOT_HOLD) && swapPending && bus.paint_done;
    nextFront = frontSel ^ swapNow;
    readBase  = nextFront ? BUF1_BASE : BUF0_BASE;
    writeBase = frontSel  ? BUF0_BASE : BUF1_BASE;
    readAddr  = readBase + bus.disp_addr;
    writeAddr = writeBase + bus.wr_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slotQ       <= SLOT_READ;
      frontSel    <= 1'b0;
      swapPending <= 1'b0;
      swapDone    <= 1'b0;
      dispValid   <= 1'b0;
      dispData    <= '0;
      wbusy       <= 1'b0;
      sramAddr    <= '0;
      sramDout    <= '0;
      sramDen     <= 1'b0;
      sramOeN     <= 1'b1;
      sramWeN     <= 1'b1;
    end else begin
      slotQ     <= slotQ + 2'd1;
      swapDone  <= swapNow;
      frontSel  <= nextFront;
      dispValid <= 1'b0;

      // A request arriving on the swap edge re-arms the next swap.
      if (swapNow)
        swapPending <= bus.swap_req;
      else if (bus.swap_req)
        swapPending <= 1'b1;

      case (slotQ)
        SLOT_HOLD: begin
          // Leaving HOLD: finish any write, then set up the slot-0 read.
          wbusy   <= 1'b0;
          sramDen <= 1'b0;
          sramWeN <= 1'b1;
          if (bus.disp_req) begin
            sramOeN  <= 1'b0;
            sramAddr <= readAddr;
          end else begin
            sramOeN  <= 1'b1;
          end
        end
        SLOT_READ: begin
          // sramOeN low here means a read is on the bus this slot.
          sramOeN <= 1'b1;
          if (!sramOeN) begin
            dispData  <= bus.sram_din;
            dispValid <= 1'b1;
          end
          // Accepted writes latch their absolute address straight into
          // sramAddr, so a later swap cannot redirect them.
          if (bus.wr_valid) begin
            wbusy    <= 1'b1;
            sramAddr <= writeAddr;
            sramDout <= bus.wr_data;
            sramDen  <= 1'b1;
          end
        end
        SLOT_SETUP: begin
          if (wbusy)
            sramWeN <= 1'b0;
        end
        SLOT_STROBE: begin
          sramWeN <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.slot         = slotQ;
  assign bus.pixel_tick   = rst && (slotQ == SLOT_HOLD);
  assign bus.wr_ready     = rst && (slotQ == SLOT_READ);
  assign bus.disp_data    = dispData;
  assign bus.disp_valid   = dispValid;
  assign bus.swap_pending = swapPending;
  assign bus.swap_done    = swapDone;
  assign bus.front_sel    = frontSel;
  assign bus.sram_addr    = sramAddr;
  assign bus.sram_dout    = sramDout;
  assign bus.sram_den     = sramDen;
  assign bus.sram_oe_n    = sramOeN;
  assign bus.sram_we_n    = sramWeN;

endmodule
